tetris_lines_checker: RTL and testbench
=======================================

TETRIS_LINES_CHECKER -- requirements
Module: tetris_lines_checker

Interface
REQ-001 SHALL have parameter ROWS, default 20, meaning the number of field rows; row 0 is the top row and row ROWS-1 is the bottom row.
REQ-002 SHALL have parameter COLS, default 10, meaning the number of cells per row; 1 = occupied.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 SHALL have port srst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port field_i, input, [ROWS-1:0][COLS-1:0]: the field after a piece has landed. Sampled only when start is accepted.
REQ-006 SHALL have port start_i, input, 1 bit: single-cycle request to check the field.
REQ-007 SHALL have port busy_o, output, 1 bit: a check is in progress.
REQ-008 SHALL have port field_o, output, [ROWS-1:0][COLS-1:0]: the working and result field.
REQ-009 SHALL have port disappear_lines_cnt_o, output, 3 bits: number of removed rows, saturated at 4.
REQ-010 SHALL have port update_stat_en_o, output, 1 bit: one-cycle pulse marking a valid result; it feeds the statistics block's update enable.

Function
REQ-011 SHALL implement the FSM states IDLE, SCAN, FILL and DONE.
REQ-012 SHALL accept start_i only in IDLE. Start is accepted in cycle 0: field_i is copied into the working buffer, the read pointer r is set to ROWS-1, the write pointer w is set to ROWS-1, the internal count is cleared, and the FSM goes to SCAN.
REQ-013 SHALL process one row per cycle in SCAN, for r = ROWS-1 down to 0:
- Row r full (all COLS bits 1): increment the count; w is unchanged.
- Row r not full: copy row r to row w, then decrement w.
REQ-014 SHALL perform the compaction in place in the working buffer; w >= r always holds, so no unread row is ever overwritten.
REQ-015 SHALL leave SCAN after the row r = 0 cycle, that is after exactly ROWS SCAN cycles (cycles 1..ROWS).
REQ-016 SHALL behave in FILL as follows:
- Clear row w to all zeros and decrement w, one row per cycle.
- Stay in FILL for exactly k cycles, where k is the full-row count.
- If k = 0, go directly from SCAN to DONE.
REQ-017 SHALL assert update_stat_en_o for exactly one cycle in DONE, at cycle ROWS+1+k after acceptance, then return to IDLE.
REQ-018 SHALL keep the internal count at width $clog2(ROWS+1) so it never wraps. disappear_lines_cnt_o = min(count, 4), registered and valid in the DONE cycle. It holds until the next accepted start, which clears it to 0.
REQ-019 SHALL remove all full rows even when the count exceeds 4; only the reported count saturates.
REQ-020 SHALL assert busy_o from cycle 1 through the DONE cycle inclusive, and deassert it in IDLE.
REQ-021 SHALL expose the working buffer directly on field_o. field_o is the final compacted field from the DONE cycle until the next accepted start.
REQ-022 SHALL ignore start_i while busy_o = 1, with no queuing. A start_i in the same cycle as DONE is also ignored.
REQ-023 SHALL preserve the relative order of the non-full rows, bottom-aligned, with the top k rows zero.

Reset
REQ-024 SHALL, on srst_i = 1 at any cycle including mid-SCAN or mid-FILL, go to IDLE on the next edge with:
- field_o = 0
- disappear_lines_cnt_o = 0
- update_stat_en_o = 0
- busy_o = 0
- pointers and count = 0
REQ-025 SHALL give srst_i priority over start_i in the same cycle.

Verification
REQ-026 SHALL cover: empty field, start -> update_stat_en_o pulse at cycle 21, cnt = 0, field_o all zero.
REQ-027 SHALL cover: row 19 = 0x3FF, row 18 = 0x001 -> pulse at cycle 22, cnt = 1, row 19 = 0x001, rows 0..18 = 0.
REQ-028 SHALL cover: rows 19, 17, 15 and 13 full; rows 18, 16, 14 = 0x201, 0x00F, 0x300 -> pulse at cycle 25, cnt = 4, rows 19/18/17 = 0x201/0x00F/0x300, rest 0.
REQ-029 SHALL cover: all 20 rows full -> pulse at cycle 41, cnt = 4 (saturated), field_o all zero.
REQ-030 SHALL cover: start_i re-pulsed at cycles 5 and 21 of a check -> both ignored, exactly one update pulse, result unchanged.
REQ-031 SHALL cover: srst_i at cycle 10 of a check -> next cycle busy_o = 0 and all outputs 0; a following start behaves as the first scenario.

Source files
------------

// File: rtl/tetris_lines_checker.sv
// Removes full rows from a Tetris field by in-place bottom-up compaction,
// then zero-fills the freed top rows and reports the saturated line count.
module tetris_lines_checker #(
   parameter int ROWS = 20,
   parameter int COLS = 10
) (
   input  logic                       clk_i,
   input  logic                       srst_i,
   input  logic [ROWS-1:0][COLS-1:0]  field_i,
   input  logic                       start_i,
   output logic                       busy_o,
   output logic [ROWS-1:0][COLS-1:0]  field_o,
   output logic [2:0]                 disappear_lines_cnt_o,
   output logic                       update_stat_en_o
);

   localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = ($clog2(ROWS + 1) < 3) ? 3 : $clog2(ROWS + 1);
   localparam logic [PW-1:0] LAST_ROW = PW'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

   state_t                      state_q, state_d;
   logic [ROWS-1:0][COLS-1:0]   field_q, field_d;
   logic [PW-1:0]               r_q, r_d;
   logic [PW-1:0]               w_q, w_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [2:0]                  lines_q, lines_d;
   logic                        stat_en_q, stat_en_d;
   logic                        busy_q, busy_d;
   logic [ROWS-1:0]             row_full;

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row_full
         assign row_full[gi] = &field_q[gi];
      end
   endgenerate

   function automatic logic [2:0] sat4(input logic [CW-1:0] c);
      return (c >= CW'(4)) ? 3'd4 : 3'(c);
   endfunction

   always_comb begin
      state_d   = state_q;
      field_d   = field_q;
      r_d       = r_q;
      w_d       = w_q;
      cnt_d     = cnt_q;
      lines_d   = lines_q;
      stat_en_d = 1'b0;
      busy_d    = busy_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               field_d = field_i;
               r_d     = LAST_ROW;
               w_d     = LAST_ROW;
               cnt_d   = '0;
               lines_d = 3'd0;
               busy_d  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (row_full[r_q]) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               // w never drops below r, so this never clobbers an unread row
               field_d[w_q] = field_q[r_q];
               w_d          = w_q - PW'(1);
            end
            if (r_q == '0) begin
               if (cnt_d == '0) begin
                  state_d   = DONE;
                  stat_en_d = 1'b1;
                  lines_d   = 3'd0;
               end else begin
                  state_d = FILL;
               end
            end else begin
               r_d = r_q - PW'(1);
            end
         end
         FILL: begin
            // after the scan w == k-1, so reaching row 0 means k rows cleared
            field_d[w_q] = '0;
            if (w_q == '0) begin
               state_d   = DONE;
               stat_en_d = 1'b1;
               lines_d   = sat4(cnt_q);
            end else begin
               w_d = w_q - PW'(1);
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q   <= IDLE;
         field_q   <= '0;
         r_q       <= '0;
         w_q       <= '0;
         cnt_q     <= '0;
         lines_q   <= 3'd0;
         stat_en_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         field_q   <= field_d;
         r_q       <= r_d;
         w_q       <= w_d;
         cnt_q     <= cnt_d;
         lines_q   <= lines_d;
         stat_en_q <= stat_en_d;
         busy_q    <= busy_d;
      end
   end

   assign busy_o                = busy_q;
   assign field_o               = field_q;
   assign disappear_lines_cnt_o = lines_q;
   assign update_stat_en_o      = stat_en_q;

endmodule

// File: tb/tb_tetris_lines_checker.sv
// Bench for tetris_lines_checker: directed vector table, random fields against
// a row-list reference model, and re-start / mid-check reset sequences.
module tb_tetris_lines_checker;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int FW   = ROWS * COLS;

   typedef logic [ROWS-1:0][COLS-1:0] field_t;

   typedef struct {
      string  name;
      field_t f;
      field_t ef;
      int     ecnt;
      int     ecyc;
   } vec_t;

   logic       clk_i = 1'b0;
   logic       srst_i;
   field_t     field_i;
   logic       start_i;
   logic       busy_o;
   field_t     field_o;
   logic [2:0] disappear_lines_cnt_o;
   logic       update_stat_en_o;

   int checks   = 0;
   int failures = 0;

   tetris_lines_checker #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk_i                 (clk_i),
      .srst_i                (srst_i),
      .field_i               (field_i),
      .start_i               (start_i),
      .busy_o                (busy_o),
      .field_o               (field_o),
      .disappear_lines_cnt_o (disappear_lines_cnt_o),
      .update_stat_en_o      (update_stat_en_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: list the surviving rows bottom-up, stack them at the bottom.
   task automatic model(input field_t f, output field_t ef, output int k);
      logic [COLS-1:0] keep[$];
      logic [COLS-1:0] full_row;
      full_row = '1;
      keep = {};
      for (int r = ROWS - 1; r >= 0; r--)
         if (f[r] != full_row) keep.push_back(f[r]);
      ef = '0;
      for (int i = 0; i < keep.size(); i++) ef[ROWS-1-i] = keep[i];
      k = ROWS - keep.size();
   endtask

   // Called at posedge+#1 with the DUT idle; drives start in that cycle (cycle 0).
   task automatic run_check(input string name, input field_t f, input field_t ef,
                            input int ecnt, input int ecyc, input int rp_a, input int rp_b);
      int pulses;
      int pcyc;
      int busy_err;
      pulses   = 0;
      pcyc     = -1;
      busy_err = 0;
      field_i  = f;
      start_i  = 1'b1;
      for (int c = 1; c <= ecyc + 3; c++) begin
         @(posedge clk_i);
         #1;
         start_i = (c == rp_a) || (c == rp_b);
         field_i = field_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         if (busy_o !== (c <= ecyc)) busy_err++;
         if (update_stat_en_o === 1'b1) begin
            pulses++;
            pcyc = c;
         end
         if (c == ecyc) begin
            chk({name, " done_cnt"}, FW'(disappear_lines_cnt_o), FW'(ecnt));
            chk({name, " done_field"}, field_o, ef);
         end
      end
      start_i = 1'b0;
      chk({name, " busy_profile_errs"}, FW'(busy_err), FW'(0));
      chk({name, " pulse_count"}, FW'(pulses), FW'(1));
      chk({name, " pulse_cycle"}, FW'(pcyc), FW'(ecyc));
      chk({name, " hold_cnt"}, FW'(disappear_lines_cnt_o), FW'(ecnt));
      chk({name, " hold_field"}, field_o, ef);
      $display("txn %s: k-cycle=%0d pulses=%0d cnt=%0d", name, ecyc, pulses, disappear_lines_cnt_o);
   endtask

   vec_t   vecs[4];
   field_t f, ef;
   int     k;

   initial begin
      srst_i  = 1'b1;
      start_i = 1'b0;
      field_i = '0;

      vecs[0].name = "empty";
      vecs[0].f = '0; vecs[0].ef = '0; vecs[0].ecnt = 0; vecs[0].ecyc = 21;

      vecs[1].name = "one_line";
      vecs[1].f = '0; vecs[1].f[19] = 10'h3FF; vecs[1].f[18] = 10'h001;
      vecs[1].ef = '0; vecs[1].ef[19] = 10'h001;
      vecs[1].ecnt = 1; vecs[1].ecyc = 22;

      vecs[2].name = "four_interleaved";
      vecs[2].f = '0;
      vecs[2].f[19] = 10'h3FF; vecs[2].f[17] = 10'h3FF;
      vecs[2].f[15] = 10'h3FF; vecs[2].f[13] = 10'h3FF;
      vecs[2].f[18] = 10'h201; vecs[2].f[16] = 10'h00F; vecs[2].f[14] = 10'h300;
      vecs[2].ef = '0;
      vecs[2].ef[19] = 10'h201; vecs[2].ef[18] = 10'h00F; vecs[2].ef[17] = 10'h300;
      vecs[2].ecnt = 4; vecs[2].ecyc = 25;

      vecs[3].name = "all_full";
      vecs[3].f = '1; vecs[3].ef = '0; vecs[3].ecnt = 4; vecs[3].ecyc = 41;

      repeat (3) @(posedge clk_i);
      #1;
      srst_i = 1'b0;
      chk("reset_busy", FW'(busy_o), FW'(0));
      chk("reset_field", field_o, '0);
      chk("reset_cnt", FW'(disappear_lines_cnt_o), FW'(0));
      chk("reset_stat", FW'(update_stat_en_o), FW'(0));

      for (int i = 0; i < 4; i++)
         run_check(vecs[i].name, vecs[i].f, vecs[i].ef, vecs[i].ecnt, vecs[i].ecyc, -1, -1);

      // start re-pulsed mid-scan and in the DONE cycle: both ignored
      run_check("repulse", vecs[0].f, vecs[0].ef, 0, 21, 5, 21);

      // reset at cycle 10 of a check
      field_i = vecs[2].f;
      start_i = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk_i);
         #1;
         start_i = 1'b0;
      end
      srst_i = 1'b1;
      @(posedge clk_i);
      #1;
      srst_i = 1'b0;
      chk("midreset_busy", FW'(busy_o), FW'(0));
      chk("midreset_field", field_o, '0);
      chk("midreset_cnt", FW'(disappear_lines_cnt_o), FW'(0));
      chk("midreset_stat", FW'(update_stat_en_o), FW'(0));
      $display("txn midreset: busy=%0d cnt=%0d", busy_o, disappear_lines_cnt_o);
      run_check("after_reset", vecs[0].f, vecs[0].ef, 0, 21, -1, -1);

      // reset wins over a simultaneous start
      run_check("pre_prio", vecs[1].f, vecs[1].ef, 1, 22, -1, -1);
      srst_i  = 1'b1;
      start_i = 1'b1;
      field_i = '1;
      @(posedge clk_i);
      #1;
      srst_i  = 1'b0;
      start_i = 1'b0;
      chk("prio_busy", FW'(busy_o), FW'(0));
      chk("prio_cnt", FW'(disappear_lines_cnt_o), FW'(0));
      @(posedge clk_i);
      #1;
      chk("prio_busy_later", FW'(busy_o), FW'(0));
      chk("prio_field", field_o, '0);
      $display("txn reset_priority: busy=%0d", busy_o);

      for (int t = 0; t < 30; t++) begin
         for (int r = 0; r < ROWS; r++)
            f[r] = ($urandom_range(2) == 0) ? '1 : COLS'($urandom);
         if (t == 0) f = '1;
         model(f, ef, k);
         run_check($sformatf("rand%0d", t), f, ef, (k > 4) ? 4 : k, ROWS + 1 + k, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
